// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Generic inter-stage pipeline register with a valid/ready handshake.
// Control bits are forced to zero on bubbles so a bubble can never assert a
// write enable downstream; data bits pass through unmasked.
// SKID != 0 builds a two-entry skid buffer so ready_o depends only on flops.
// SKID == 0 builds a single register whose ready_o is combinational.
// A saturating counter reports how many cycles valid_o was low (CPI studies).
//
// Ports
//   clk_i         clock, rising edge
//   rst_n_i       asynchronous active-low reset
//   flush_i       kill held entries and the incoming entry
//   valid_i       upstream entry valid
//   ready_o       this stage can accept an entry
//   ctrl_i        upstream control bits  [CTRL_W-1:0]
//   data_i        upstream data bits     [DATA_W-1:0]
//   valid_o       downstream entry valid
//   ready_i       downstream accepts (0 = hazard stall)
//   ctrl_o        control out, zero whenever valid_o is low
//   data_o        data out, don't-care whenever valid_o is low
//   cnt_clr_i     synchronous clear of the bubble counter
//   bubble_cnt_o  saturating count of cycles with valid_o low
module pipe_stage_reg #(
   parameter int CTRL_W = 8,
   parameter int DATA_W = 128,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o,
   input  logic              cnt_clr_i,
   output logic [CNT_W-1:0]  bubble_cnt_o
);

   logic              in_fire;
   logic              out_fire;
   logic [CTRL_W-1:0] ctrl_main;
   logic [CNT_W-1:0]  bubble_cnt_q;
   logic [CNT_W-1:0]  bubble_cnt_d;

   assign in_fire  = valid_i & ready_o;
   assign out_fire = valid_o & ready_i;

   // The held control word is only meaningful with valid_o; a bubble shows zeros.
   assign ctrl_o = valid_o ? ctrl_main : '0;

   generate
      if (SKID != 0) begin : g_skid
         typedef enum logic [1:0] {
            EMPTY = 2'd0,
            ONE   = 2'd1,
            FULL  = 2'd2
         } state_t;

         state_t            state_q, state_d;
         logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
         logic [DATA_W-1:0] main_data_q, main_data_d;
         logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
         logic [DATA_W-1:0] skid_data_q, skid_data_d;

         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               state_q     <= EMPTY;
               main_ctrl_q <= '0;
               main_data_q <= '0;
               skid_ctrl_q <= '0;
               skid_data_q <= '0;
            end else begin
               state_q     <= state_d;
               main_ctrl_q <= main_ctrl_d;
               main_data_q <= main_data_d;
               skid_ctrl_q <= skid_ctrl_d;
               skid_data_q <= skid_data_d;
            end
         end

         // The main register always feeds the outputs; the skid register only
         // catches the entry accepted in the same cycle the downstream stalls.
         always_comb begin
            state_d     = state_q;
            main_ctrl_d = main_ctrl_q;
            main_data_d = main_data_q;
            skid_ctrl_d = skid_ctrl_q;
            skid_data_d = skid_data_q;
            case (state_q)
               EMPTY: begin
                  if (in_fire) begin
                     state_d     = ONE;
                     main_ctrl_d = ctrl_i;
                     main_data_d = data_i;
                  end
               end
               ONE: begin
                  if (in_fire && out_fire) begin
                     main_ctrl_d = ctrl_i;
                     main_data_d = data_i;
                  end else if (in_fire) begin
                     state_d     = FULL;
                     skid_ctrl_d = ctrl_i;
                     skid_data_d = data_i;
                  end else if (out_fire) begin
                     state_d = EMPTY;
                  end
               end
               FULL: begin
                  if (out_fire) begin
                     state_d     = ONE;
                     main_ctrl_d = skid_ctrl_q;
                     main_data_d = skid_data_q;
                  end
               end
               default: state_d = EMPTY;
            endcase
            // Flush overrides everything: control is scrubbed, data is simply held.
            if (flush_i) begin
               state_d     = EMPTY;
               main_ctrl_d = '0;
               skid_ctrl_d = '0;
               main_data_d = main_data_q;
               skid_data_d = skid_data_q;
            end
         end

         assign valid_o   = (state_q != EMPTY);
         assign ready_o   = (state_q != FULL);
         assign ctrl_main = main_ctrl_q;
         assign data_o    = main_data_q;
      end else begin : g_single
         logic              valid_q, valid_d;
         logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
         logic [DATA_W-1:0] main_data_q, main_data_d;

         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               valid_q     <= 1'b0;
               main_ctrl_q <= '0;
               main_data_q <= '0;
            end else begin
               valid_q     <= valid_d;
               main_ctrl_q <= main_ctrl_d;
               main_data_q <= main_data_d;
            end
         end

         // Single entry: accept whenever the held entry leaves this cycle or none is held.
         always_comb begin
            valid_d     = valid_q;
            main_ctrl_d = main_ctrl_q;
            main_data_d = main_data_q;
            if (in_fire) begin
               valid_d     = 1'b1;
               main_ctrl_d = ctrl_i;
               main_data_d = data_i;
            end else if (out_fire) begin
               valid_d = 1'b0;
            end
            if (flush_i) begin
               valid_d     = 1'b0;
               main_ctrl_d = '0;
               main_data_d = main_data_q;
            end
         end

         assign valid_o   = valid_q;
         assign ready_o   = ready_i | ~valid_q;
         assign ctrl_main = main_ctrl_q;
         assign data_o    = main_data_q;
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         bubble_cnt_q <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   // Clear beats increment; the count sticks at all-ones instead of wrapping.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (cnt_clr_i) begin
         bubble_cnt_d = '0;
      end else if (!valid_o && (bubble_cnt_q != {CNT_W{1'b1}})) begin
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
   end

   assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: a skid instance (SKID=1, 4-bit counter) and a
// single-entry instance (SKID=0, 16-bit counter) share every input. Each has a
// queue holding the entries it has accepted but not yet delivered; the queue
// depth gives the expected valid_o/ready_o and its head the expected output.
module tb_pipe_stage_reg;

   localparam int CTRL_W = 8;
   localparam int DATA_W = 128;

   typedef struct packed {
      logic [CTRL_W-1:0] c;
      logic [DATA_W-1:0] d;
   } entry_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic              valid_in = 1'b0;
   logic              ready_in = 1'b0;
   logic [CTRL_W-1:0] ctrl_in = '0;
   logic [DATA_W-1:0] data_in = '0;
   logic              cnt_clr = 1'b0;

   logic              s1_ready, s1_valid;
   logic [CTRL_W-1:0] s1_ctrl;
   logic [DATA_W-1:0] s1_data;
   logic [3:0]        s1_cnt;

   logic              s0_ready, s0_valid;
   logic [CTRL_W-1:0] s0_ctrl;
   logic [DATA_W-1:0] s0_data;
   logic [15:0]       s0_cnt;

   entry_t q1[$];
   entry_t q0[$];
   int     cnt1 = 0;
   int     cnt0 = 0;

   int compareCount  = 0;
   int mismatchCount = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1), .CNT_W(4)) dut_s1 (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .valid_i(valid_in),
      .ready_o(s1_ready), .ctrl_i(ctrl_in), .data_i(data_in), .valid_o(s1_valid),
      .ready_i(ready_in), .ctrl_o(s1_ctrl), .data_o(s1_data), .cnt_clr_i(cnt_clr),
      .bubble_cnt_o(s1_cnt)
   );

   pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0), .CNT_W(16)) dut_s0 (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .valid_i(valid_in),
      .ready_o(s0_ready), .ctrl_i(ctrl_in), .data_i(data_in), .valid_o(s0_valid),
      .ready_i(ready_in), .ctrl_o(s0_ctrl), .data_o(s0_data), .cnt_clr_i(cnt_clr),
      .bubble_cnt_o(s0_cnt)
   );

   // Single comparison point: counts and reports one observed/expected pair.
   task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                              input logic [DATA_W-1:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reset check: outputs must clear immediately, without waiting for a clock edge.
   task automatic checkReset();
      rst_n = 1'b0;
      #1;
      checkOutput("s1.rst.valid", DATA_W'(s1_valid), '0);
      checkOutput("s1.rst.ctrl",  DATA_W'(s1_ctrl),  '0);
      checkOutput("s1.rst.ready", DATA_W'(s1_ready), DATA_W'(1));
      checkOutput("s1.rst.cnt",   DATA_W'(s1_cnt),   '0);
      checkOutput("s1.rst.data",  s1_data,           '0);
      checkOutput("s0.rst.valid", DATA_W'(s0_valid), '0);
      checkOutput("s0.rst.ctrl",  DATA_W'(s0_ctrl),  '0);
      checkOutput("s0.rst.ready", DATA_W'(s0_ready), DATA_W'(1));
      checkOutput("s0.rst.cnt",   DATA_W'(s0_cnt),   '0);
      q1.delete();
      q0.delete();
      cnt1 = 0;
      cnt0 = 0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One cycle: drive at the falling edge, check 1 ns later, update the model
   // at the rising edge, then return at the next falling edge.
   task automatic applyStimulus(input logic v, input logic [CTRL_W-1:0] c,
                                input logic [DATA_W-1:0] d, input logic r,
                                input logic fl, input logic clr);
      logic   e1v, e1r, e0v, e0r;
      entry_t e;
      valid_in = v;
      ctrl_in  = c;
      data_in  = d;
      ready_in = r;
      flush    = fl;
      cnt_clr  = clr;
      #1;
      e1v = (q1.size() != 0);
      e1r = (q1.size() < 2);
      e0v = (q0.size() != 0);
      e0r = r | (q0.size() == 0);
      checkOutput("s1.valid", DATA_W'(s1_valid), DATA_W'(e1v));
      checkOutput("s1.ready", DATA_W'(s1_ready), DATA_W'(e1r));
      checkOutput("s1.cnt",   DATA_W'(s1_cnt),   DATA_W'(cnt1));
      checkOutput("s0.valid", DATA_W'(s0_valid), DATA_W'(e0v));
      checkOutput("s0.ready", DATA_W'(s0_ready), DATA_W'(e0r));
      checkOutput("s0.cnt",   DATA_W'(s0_cnt),   DATA_W'(cnt0));
      if (e1v) begin
         checkOutput("s1.ctrl", DATA_W'(s1_ctrl), DATA_W'(q1[0].c));
         checkOutput("s1.data", s1_data, q1[0].d);
      end else begin
         checkOutput("s1.ctrl_bubble", DATA_W'(s1_ctrl), '0);
      end
      if (e0v) begin
         checkOutput("s0.ctrl", DATA_W'(s0_ctrl), DATA_W'(q0[0].c));
         checkOutput("s0.data", s0_data, q0[0].d);
      end else begin
         checkOutput("s0.ctrl_bubble", DATA_W'(s0_ctrl), '0);
      end
      @(posedge clk);
      e.c = c;
      e.d = d;
      if (fl) begin
         q1.delete();
         q0.delete();
      end else begin
         if (e1v && r) void'(q1.pop_front());
         if (v && e1r) q1.push_back(e);
         if (e0v && r) void'(q0.pop_front());
         if (v && e0r) q0.push_back(e);
      end
      if (clr) cnt1 = 0;
      else if (!e1v && cnt1 < 15) cnt1++;
      if (clr) cnt0 = 0;
      else if (!e0v && cnt0 < 65535) cnt0++;
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      checkReset();

      // Full-rate streaming.
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b1, CTRL_W'(i), DATA_W'(32'h100 + i), 1'b1, 1'b0, 1'b0);

      // Downstream stall with upstream still pushing, then drain.
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, CTRL_W'(8'h20 + i), DATA_W'(32'h200 + i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

      // Fill while stalled, then flush with an incoming entry and a stalled one.
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, CTRL_W'(8'h30 + i), DATA_W'(32'h300 + i), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h3F, DATA_W'(32'h3FF), 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

      // Idle with all-ones control: bubbles stay masked and the 4-bit counter saturates.
      for (int i = 0; i < 20; i++)
         applyStimulus(1'b0, 8'hFF, '0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'hFF, '0, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'hFF, '0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'hFF, '0, 1'b1, 1'b0, 1'b0);

      // Random traffic: mixed valid, stalls and rare flushes.
      for (int i = 0; i < 60; i++)
         applyStimulus(1'($urandom_range(0, 1)), CTRL_W'($urandom),
                       {$urandom, $urandom, $urandom, $urandom},
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 1'b0);

      // Asynchronous reset in the middle of a stalled stream.
      for (int i = 0; i < 2; i++)
         applyStimulus(1'b1, CTRL_W'(8'h50 + i), DATA_W'(32'h500 + i), 1'b0, 1'b0, 1'b0);
      #3;
      checkReset();
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, CTRL_W'(8'h60 + i), DATA_W'(32'h600 + i), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
